adc_serial_rx: RTL and testbench

Parametrised multi-channel serial ADC receiver for SPI-style converters: 12-bit sample in a 16-clock frame, leading zeros, MSB first. It generates `cs_n` and `sclk` itself from the system clock and captures `NUM_CH` data lines in parallel. It presents each completed sample set on a valid/ready output port and flags overruns. It sits between the board ADC pins and the equalizer filter bank input, and replaces the fixed single-channel, externally clocked receiver.

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_sclk_gen.sv | 52 +++++
 rtl/adc_serial_rx.sv | 138 +++++++++++++
 tb/tb_adc_serial_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared types and helpers for the multi-channel serial ADC receiver.
package adc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      QUIET
   } adc_state_t;

   localparam logic SCLK_IDLE = 1'b1;

   // Width of a counter that must hold the values 0 .. count-1.
   function automatic int cntWidth(input int count);
      return (count < 2) ? 1 : $clog2(count);
   endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// Serial clock divider: toggles sclk every CLK_DIV clk cycles and strobes the edge it is about to make.
module adc_sclk_gen
   import adc_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic sclk_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int DIV_W = cntWidth(CLK_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic             sclk_q, sclk_d;
   logic             wrap;

   assign wrap = (div_q == DIV_W'(CLK_DIV - 1));

   // Clear parks sclk at its idle level so a new frame always starts with a fall.
   always_comb begin
      div_d  = div_q;
      sclk_d = sclk_q;
      if (clear_i) begin
         div_d  = '0;
         sclk_d = SCLK_IDLE;
      end else if (wrap) begin
         div_d  = '0;
         sclk_d = ~sclk_q;
      end else begin
         div_d = div_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_q  <= '0;
         sclk_q <= SCLK_IDLE;
      end else begin
         div_q  <= div_d;
         sclk_q <= sclk_d;
      end
   end

   assign sclk_o = sclk_q;
   assign rise_o = ~clear_i & wrap & ~sclk_q;
   assign fall_o = ~clear_i & wrap & sclk_q;

endmodule

// File: rtl/adc_serial_rx.sv
// Multi-channel SPI-style ADC receiver: drives cs_n/sclk, shifts NUM_CH lines in parallel and
// presents each completed sample set on a valid/ready port with overrun flagging.
module adc_serial_rx
   import adc_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int FRAME_LEN = 16,
   parameter int NUM_CH    = 2,
   parameter int CLK_DIV   = 4,
   parameter int QUIET_CYC = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NUM_CH-1:0]        sdata,
   output logic                     cs_n,
   output logic                     sclk,
   output logic [NUM_CH*DATA_W-1:0] data_out,
   output logic                     valid,
   input  logic                     ready,
   output logic                     overrun
);

   localparam int BIT_W   = cntWidth(FRAME_LEN);
   localparam int QUIET_W = cntWidth(QUIET_CYC);

   adc_state_t                state_q, state_d;
   logic [BIT_W-1:0]          bitCnt_q, bitCnt_d;
   logic [QUIET_W-1:0]        quietCnt_q, quietCnt_d;
   logic                      csN_q;
   logic [NUM_CH*DATA_W-1:0]  dataOut_q, dataOut_d;
   logic [NUM_CH*DATA_W-1:0]  loadData;
   logic                      valid_q, valid_d;
   logic                      overrun_q, overrun_d;
   logic                      sclkRise;
   logic                      unusedSclkFall;
   logic                      lastBit;

   adc_sclk_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_sclk_gen (
      .clk    (clk),
      .rst    (rst),
      .clear_i(state_q != SHIFT),
      .sclk_o (sclk),
      .rise_o (sclkRise),
      .fall_o (unusedSclkFall)
   );

   assign lastBit = sclkRise & (bitCnt_q == BIT_W'(FRAME_LEN - 1));

   // Only the newest DATA_W-1 bits are kept per line; the leading frame bits shift out unseen.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic [DATA_W-2:0] hist_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            hist_q <= '0;
         end else if (sclkRise) begin
            hist_q <= {hist_q[DATA_W-3:0], sdata[c]};
         end
      end

      assign loadData[c*DATA_W +: DATA_W] = {hist_q, sdata[c]};
   end

   // Frame sequencing: a started frame always runs to completion; en is only consulted at frame boundaries.
   always_comb begin
      state_d    = state_q;
      bitCnt_d   = bitCnt_q;
      quietCnt_d = quietCnt_q;
      unique case (state_q)
         IDLE: begin
            bitCnt_d   = '0;
            quietCnt_d = '0;
            if (en) state_d = SHIFT;
         end
         SHIFT: begin
            if (lastBit) begin
               state_d    = QUIET;
               bitCnt_d   = '0;
               quietCnt_d = '0;
            end else if (sclkRise) begin
               bitCnt_d = bitCnt_q + BIT_W'(1);
            end
         end
         QUIET: begin
            if (quietCnt_q == QUIET_W'(QUIET_CYC - 1)) begin
               quietCnt_d = '0;
               state_d    = en ? SHIFT : IDLE;
            end else begin
               quietCnt_d = quietCnt_q + QUIET_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A load always wins over a consume; overrun only when the old set was neither consumed nor kept.
   always_comb begin
      dataOut_d = dataOut_q;
      valid_d   = valid_q;
      overrun_d = 1'b0;
      if (lastBit) begin
         dataOut_d = loadData;
         valid_d   = 1'b1;
         overrun_d = valid_q & ~ready;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         bitCnt_q   <= '0;
         quietCnt_q <= '0;
         csN_q      <= 1'b1;
         dataOut_q  <= '0;
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         bitCnt_q   <= bitCnt_d;
         quietCnt_q <= quietCnt_d;
         csN_q      <= (state_d != SHIFT);
         dataOut_q  <= dataOut_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign cs_n     = csN_q;
   assign data_out = dataOut_q;
   assign valid    = valid_q;
   assign overrun  = overrun_q;

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: ADC pin model plus a frame-level scoreboard of the output port.
module tb_adc_serial_rx;

   localparam int DW        = 12;
   localparam int FL        = 16;
   localparam int NCH       = 2;
   localparam int CD        = 2;
   localparam int QC        = 4;
   localparam int FRAME_CYC = 2 * CD * FL;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            en = 1'b0;
   logic            ready = 1'b0;
   logic [NCH-1:0]  sdata = '0;
   logic            cs_n, sclk, valid, overrun;
   logic [NCH*DW-1:0] data_out;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   adc_serial_rx #(
      .DATA_W(DW), .FRAME_LEN(FL), .NUM_CH(NCH), .CLK_DIV(CD), .QUIET_CYC(QC)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sdata(sdata), .cs_n(cs_n), .sclk(sclk),
      .data_out(data_out), .valid(valid), .ready(ready), .overrun(overrun)
   );

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ADC model: each frame word goes out MSB first, one bit per sclk fall.
   logic [31:0] wordQ[$];
   logic [15:0] curW0 = '0, curW1 = '0;
   int          bitIdx = 0;

   always @(negedge cs_n) begin
      if (wordQ.size() > 0) {curW1, curW0} = wordQ.pop_front();
      else {curW1, curW0} = $urandom();
      bitIdx = 0;
   end

   always @(negedge sclk) begin
      if (cs_n === 1'b0 && bitIdx < FL) begin
         sdata[0] = curW0[FL-1-bitIdx];
         sdata[1] = curW1[FL-1-bitIdx];
         bitIdx++;
      end
   end

   // Scoreboard: frame timing from the pins, and a held-set/handshake model of the output port.
   logic        csPrev = 1'b1, sclkPrev = 1'b1, readyPrev = 1'b0;
   logic        inFrame = 1'b0, afterFrame = 1'b0, mValid = 1'b0, expOv;
   logic [23:0] mData = '0;
   int lowCnt = 0, highCnt = 0, riseCnt = 0, firstFall = 0, lastGap = 0;
   int frameCount = 0, overrunCount = 0;

   always @(negedge clk) begin
      if (rst) begin
         mValid = 1'b0; mData = '0; inFrame = 1'b0; afterFrame = 1'b0;
         checkOutput("rstCsN", cs_n, 1);
         checkOutput("rstSclk", sclk, 1);
         checkOutput("rstValid", valid, 0);
         checkOutput("rstData", data_out, 0);
         checkOutput("rstOverrun", overrun, 0);
      end else begin
         expOv = 1'b0;
         if (csPrev && !cs_n) begin
            if (afterFrame) begin
               checkOutput("quietGapMin", highCnt >= QC, 1);
               lastGap = highCnt;
            end
            inFrame = 1'b1; lowCnt = 0; riseCnt = 0; firstFall = 0;
         end
         if (inFrame && !sclkPrev && sclk) riseCnt++;
         if (!cs_n) begin
            lowCnt++;
            if (sclkPrev && !sclk && firstFall == 0) firstFall = lowCnt - 1;
         end else begin
            highCnt++;
            checkOutput("sclkIdleHigh", sclk, 1);
         end
         if (!csPrev && cs_n && inFrame) begin
            checkOutput("csLowCycles", lowCnt, FRAME_CYC);
            checkOutput("sclkRises", riseCnt, FL);
            checkOutput("firstFallCycle", firstFall, CD);
            expOv = mValid && !readyPrev;
            mValid = 1'b1;
            mData = {curW1[DW-1:0], curW0[DW-1:0]};
            frameCount++;
            inFrame = 1'b0; afterFrame = 1'b1; highCnt = 1;
         end else if (mValid && readyPrev) begin
            mValid = 1'b0;
         end
         checkOutput("valid", valid, mValid);
         checkOutput("overrun", overrun, expOv);
         if (mValid) checkOutput("dataOut", data_out, mData);
         if (overrun === 1'b1) overrunCount++;
      end
      csPrev = cs_n; sclkPrev = sclk; readyPrev = ready;
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic e, input logic r);
      en = e;
      ready = r;
   endtask

   task automatic waitFrames(input int n, input int limit);
      int target;
      int c;
      target = frameCount + n;
      c = 0;
      while (frameCount < target && c < limit) begin
         cyc(1);
         c++;
      end
      checkOutput("frameTimeout", frameCount >= target, 1);
   endtask

   task automatic waitCsFall(input int limit);
      int c;
      c = 0;
      while (cs_n !== 1'b0 && c < limit) begin
         cyc(1);
         c++;
      end
      checkOutput("csFallTimeout", cs_n, 0);
   endtask

   int fc, ovBefore;

   initial begin
      #1 rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      cyc(2);

      $display("[TB] single frame");
      wordQ.push_back({16'h0123, 16'h0ABC});
      fc = frameCount;
      applyStimulus(1, 1);
      cyc(1);
      applyStimulus(0, 1);
      waitFrames(1, 200);
      cyc(20);
      checkOutput("singleIdleCsN", cs_n, 1);
      checkOutput("singleFrameCount", frameCount, fc + 1);

      $display("[TB] continuous frames");
      wordQ.push_back({16'h0FFF, 16'h0001});
      wordQ.push_back({16'h07FF, 16'h0800});
      wordQ.push_back({16'h0AAA, 16'h0555});
      applyStimulus(1, 1);
      waitFrames(2, 400);
      checkOutput("contGap2", lastGap, QC);
      waitFrames(1, 200);
      applyStimulus(0, 1);
      checkOutput("contGap3", lastGap, QC);
      cyc(20);

      $display("[TB] backpressure");
      ovBefore = overrunCount;
      wordQ.push_back({16'h0222, 16'h0111});
      wordQ.push_back({16'h0444, 16'h0333});
      applyStimulus(1, 0);
      waitFrames(2, 400);
      applyStimulus(0, 0);
      checkOutput("bpData", data_out, 24'h444333);
      checkOutput("bpValid", valid, 1);
      checkOutput("bpOverruns", overrunCount - ovBefore, 1);
      cyc(8);
      applyStimulus(0, 1);
      cyc(1);
      applyStimulus(0, 0);
      checkOutput("bpConsumed", valid, 0);
      cyc(5);

      $display("[TB] consume and load on the same edge");
      ovBefore = overrunCount;
      wordQ.push_back({16'h0BEE, 16'h0CAF});
      wordQ.push_back({16'h0DAD, 16'h0FED});
      applyStimulus(1, 0);
      waitFrames(1, 200);
      waitCsFall(20);
      cyc(FRAME_CYC - 1);
      applyStimulus(0, 1);
      cyc(1);
      applyStimulus(0, 0);
      checkOutput("simData", data_out, 24'hDADFED);
      checkOutput("simValid", valid, 1);
      checkOutput("simOverruns", overrunCount - ovBefore, 0);
      cyc(10);

      $display("[TB] reset mid-frame");
      applyStimulus(1, 0);
      waitCsFall(20);
      cyc(30);
      rst = 1'b1;
      #1;
      checkOutput("midRstCsN", cs_n, 1);
      checkOutput("midRstSclk", sclk, 1);
      checkOutput("midRstValid", valid, 0);
      checkOutput("midRstData", data_out, 0);
      cyc(2);
      wordQ.push_back({16'h0321, 16'h0654});
      rst = 1'b0;
      applyStimulus(1, 0);
      waitFrames(1, 200);
      applyStimulus(0, 0);
      checkOutput("postRstData", data_out, 24'h321654);
      applyStimulus(0, 1);
      cyc(20);

      $display("[TB] en dropped mid-frame");
      wordQ.push_back({16'h0F0F, 16'h00F0});
      fc = frameCount;
      applyStimulus(1, 1);
      waitCsFall(20);
      cyc(10);
      applyStimulus(0, 1);
      waitFrames(1, 200);
      cyc(40);
      checkOutput("enDropCsN", cs_n, 1);
      checkOutput("enDropFrames", frameCount, fc + 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 8; i++) wordQ.push_back($urandom());
      fc = frameCount;
      begin
         int c;
         c = 0;
         applyStimulus(1, 1);
         while (frameCount < fc + 8 && c < 1500) begin
            applyStimulus(1, 1'($urandom_range(0, 1)));
            cyc(1);
            c++;
         end
      end
      applyStimulus(0, 1);
      checkOutput("randFrames", frameCount >= fc + 8, 1);
      cyc(80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
